memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Y86 pipeline MEMORY stage, directly downstream of execute. Consumes the M_* pipeline register,
//  reads/writes a word-addressed 64-bit data memory, merges memory-address faults into status,
//  and drives the W_* register consumed by writeback.
//  Also exports m_valM/m_stat combinationally for forwarding and pipeline control.
// PARAMETERS
//  DEPTH   256  data memory size in 64-bit words; valid addresses 0..DEPTH-1
//  ADDR_W  8    index width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk      in   1   sole clock; all state updates on posedge
//  rst_n    in   1   synchronous, active-low reset
//  M_stat   in   4   status from execute ([0:3], one-hot, see package)
//  M_icode  in   4   instruction code
//  M_Cnd    in   1   condition flag (passed through, unused internally)
//  M_valE   in   64  ALU result / effective address (signed)
//  M_valA   in   64  store data / stack-pointer source (signed)
//  M_destE  in   4   dest register for valE (4'hF = none)
//  M_destM  in   4   dest register for valM (4'hF = none)
//  W_stall  in   1   hold W register contents
//  W_bubble in   1   load NOP bubble into W register
//  m_valM   out  64  combinational read data
//  m_stat   out  4   combinational status after address check
//  W_stat, W_icode, W_valE, W_valM, W_destE, W_destM  out  4/4/64/64/4/4  W register
// BEHAVIOUR
//  - Address select: mrmovq(5), rmmovq(4), call(8), pushq(A) use M_valE; ret(9), popq(B) use M_valA.
//  - mem_read = icode in {5,9,B}; mem_write = icode in {4,8,A}; any other icode: no access.
//  - Write data = M_valA (call stores return address carried in valA).
//  - dmem_error = (mem_read|mem_write) && (addr < 0 || addr >= DEPTH), signed compare on 64 bits.
//  - m_stat = dmem_error ? STAT_ADR : M_stat.
//  - m_valM = (mem_read && !dmem_error) ? mem[addr] : 0. Read is combinational, same cycle.
//  - Write commit: on posedge when mem_write && !dmem_error && M_stat==STAT_AOK && W_stat==STAT_AOK
//    && rst_n. Suppressed after any downstream exception, so no store follows a fault.
//  - Simultaneous read/write to the same word cannot occur (one instruction per cycle).
//    A read in the cycle after a write returns the new data.
//  - W register update priority per posedge: !rst_n > W_bubble > W_stall > load.
//    load: W_stat<=m_stat, W_icode<=M_icode, W_valE<=M_valE, W_valM<=m_valM,
//          W_destE<=M_destE, W_destM<=M_destM.
//    bubble: W_stat=AOK, W_icode=NOP(1), W_valE=0, W_valM=0, W_destE=W_destM=4'hF.
//    W_bubble and W_stall both high: bubble wins.
//  - Reset (rst_n=0 at posedge): W register takes bubble values.
//    Memory contents are NOT cleared; tests preload explicitly.
//    Reset mid-operation drops the in-flight instruction and suppresses its write.
//  - Address index uses addr[ADDR_W-1:0] only after the bounds check passes; no wrap-around.
// STRUCTURE
//  - y86_pkg (shared):
//    icode constants HALT=0 NOP=1 CMOV=2 IRMOV=3 RMMOV=4 MRMOV=5 OPQ=6 JXX=7 CALL=8 RET=9 PUSH=A POP=B;
//    STAT_AOK=4'b1000 STAT_HLT=4'b0100 STAT_ADR=4'b0010 STAT_INS=4'b0001; RNONE=4'hF.
//  - Sub-module data_memory (DEPTH, ADDR_W): async read port, sync write port, we/addr/wdata/rdata.
//  - memory_stage: address/control decode, fault check, W pipeline register.
// TESTING
//  1 rmmovq M_valE=5 M_valA=0x1234 AOK, then mrmovq M_valE=5
//    -> mem[5]=0x1234, next cycle m_valM=0x1234, W_valM=0x1234 one cycle later.
//  2 popq M_valA=7 with mem[7]=0xAB, M_valE=8
//    -> m_valM=0xAB; W_valE=8, W_valM=0xAB, W_icode=B.
//  3 pushq M_valE=300 (DEPTH=256)
//    -> m_stat=STAT_ADR, no write; W_stat=ADR. Next rmmovq to addr 3 with W_stat=ADR -> mem[3] unchanged.
//  4 mrmovq M_valE=-1 -> m_stat=ADR, m_valM=0.
//    irmovq (3) M_valE=-1 -> m_stat=M_stat (no access, no fault).
//  5 W_stall=1 for 2 cycles with changing M_* -> W_* frozen.
//    W_bubble=1 (with W_stall=1) -> W_icode=1, W_destE=W_destM=F, W_stat=AOK.
//  6 rst_n=0 during rmmovq to addr 2
//    -> mem[2] unchanged, W_* = bubble values. Release rst_n -> normal loads resume next posedge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, one-hot status codes, register IDs,
// the writeback pipeline register layout and the memory-access decode helpers.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dest_e;
        logic [3:0]  dest_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        stat:   STAT_AOK,
        icode:  I_NOP,
        val_e:  64'd0,
        val_m:  64'd0,
        dest_e: RNONE,
        dest_m: RNONE
    };

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOV) || (icode == I_RET) || (icode == I_POP);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOV) || (icode == I_CALL) || (icode == I_PUSH);
    endfunction

    // ret/popq address the stack through the old stack pointer carried in valA.
    function automatic logic addr_from_val_a(input logic [3:0] icode);
        return (icode == I_RET) || (icode == I_POP);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Bundle between the M pipeline register, the memory stage and the W register consumers.
interface memory_stage_if;
    logic [3:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_destE;
    logic [3:0]  M_destM;
    logic        W_stall;
    logic        W_bubble;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_destE;
    logic [3:0]  W_destM;

    modport master (
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM, W_stall, W_bubble,
        input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_destE, W_destM
    );

    modport slave (
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM, W_stall, W_bubble,
        output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_destE, W_destM
    );
endinterface

// File: rtl/memory_stage_data_memory.sv
// Word-addressed 64-bit data memory: combinational read, write on posedge when i_we.
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    output logic [63:0]       o_rdata
);

    logic [63:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// Y86 memory stage: decodes the access, range-checks the address, drives the data memory
// and the W pipeline register; m_valM/m_stat are exported combinationally for forwarding.
module memory_stage
    import y86_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_stage_if.slave  bus
);

    logic signed [63:0] w_addr;
    logic               w_rd;
    logic               w_wr;
    logic               w_dmem_error;
    logic               w_access_ok;
    logic               w_we;
    logic [ADDR_W-1:0]  w_index;
    logic [63:0]        w_rdata;
    logic [3:0]         w_m_stat;
    logic [63:0]        w_m_val_m;
    w_reg_t             w_load;
    w_reg_t             r_w;

    assign w_rd   = is_mem_read(bus.M_icode);
    assign w_wr   = is_mem_write(bus.M_icode);
    assign w_addr = addr_from_val_a(bus.M_icode) ? bus.M_valA : bus.M_valE;

    // Full 64-bit signed check so large or negative addresses never alias into the array.
    assign w_dmem_error = (w_rd || w_wr) &&
                          (w_addr < 64'sd0 || w_addr >= $signed(64'(DEPTH)));
    assign w_access_ok  = (w_rd || w_wr) && !w_dmem_error;
    assign w_index      = w_access_ok ? w_addr[ADDR_W-1:0] : '0;

    // A store is dropped if this or the previous instruction has already faulted.
    assign w_we = w_wr && !w_dmem_error && (bus.M_stat == STAT_AOK) &&
                  (r_w.stat == STAT_AOK) && rst_n;

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_index),
        .i_wdata (bus.M_valA),
        .o_rdata (w_rdata)
    );

    assign w_m_stat  = w_dmem_error ? STAT_ADR : bus.M_stat;
    assign w_m_val_m = (w_rd && !w_dmem_error) ? w_rdata : 64'd0;

    always_comb begin
        w_load        = W_BUBBLE;
        w_load.stat   = w_m_stat;
        w_load.icode  = bus.M_icode;
        w_load.val_e  = bus.M_valE;
        w_load.val_m  = w_m_val_m;
        w_load.dest_e = bus.M_destE;
        w_load.dest_m = bus.M_destM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w <= W_BUBBLE;
        end else if (bus.W_bubble) begin
            r_w <= W_BUBBLE;
        end else if (!bus.W_stall) begin
            r_w <= w_load;
        end
    end

    assign bus.m_stat  = w_m_stat;
    assign bus.m_valM  = w_m_val_m;
    assign bus.W_stat  = r_w.stat;
    assign bus.W_icode = r_w.icode;
    assign bus.W_valE  = r_w.val_e;
    assign bus.W_valM  = r_w.val_m;
    assign bus.W_destE = r_w.dest_e;
    assign bus.W_destM = r_w.dest_m;

endmodule
